// File: rtl/battle_menu_ctrl_pkg.sv
// Shared definitions for the battle menu controller.
//
// Holds the move and FSM state enums, the scene and winner codes, the HID
// keycodes the menu reacts to, and two small helpers used when a round is
// resolved: the move-beats-move rule and the saturating hit-point subtract.
package battle_menu_ctrl_pkg;

    // Move encoding as shown by the menu cursor
    typedef enum logic [1:0] {
        MOVE_ROCK  = 2'd0,
        MOVE_CUT   = 2'd1,
        MOVE_PAPER = 2'd2,
        MOVE_RUN   = 2'd3
    } move_t;

    // Battle flow states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEL_A,
        ST_SEL_B,
        ST_EXEC,
        ST_RESOLVE,
        ST_DONE
    } state_t;

    // Scene codes driven to the renderer
    localparam logic [1:0] SCENE_OVERWORLD = 2'b01;
    localparam logic [1:0] SCENE_BATTLE    = 2'b10;

    // USB HID keycodes
    localparam logic [7:0] KEY_UP    = 8'h52;
    localparam logic [7:0] KEY_DOWN  = 8'h51;
    localparam logic [7:0] KEY_ENTER = 8'h28;

    // Winner codes
    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_A    = 2'b01;
    localparam logic [1:0] WIN_B    = 2'b10;

    // True when move x defeats move y (RUN never takes part in a round)
    function automatic logic beats(input move_t x, input move_t y);
        return (x == MOVE_ROCK  && y == MOVE_CUT)   ||
               (x == MOVE_CUT   && y == MOVE_PAPER) ||
               (x == MOVE_PAPER && y == MOVE_ROCK);
    endfunction

    // hp - dmg computed one bit wider so a borrow shows up in bit 4 and
    // clamps the result to zero
    function automatic logic [3:0] sat_sub(input logic [3:0] hp, input logic [3:0] dmg);
        logic [4:0] diff;
        diff = {1'b0, hp} - {1'b0, dmg};
        return diff[4] ? 4'd0 : diff[3:0];
    endfunction

endpackage

// File: rtl/battle_menu_ctrl_key_edge_detect.sv
// Key event detector for the battle menu.
//
// Registers the previous keycode and raises press for one cycle when a
// nonzero keycode appears that differs from the last cycle's value, so a
// held key produces a single event.
//
// Ports:
//   Clk     - system clock
//   Reset   - synchronous active-high reset, clears the previous keycode
//   keycode - current HID keycode, 0 = no key
//   press   - one-cycle key event
//   code    - keycode belonging to the event
module key_edge_detect (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    output logic       press,
    output logic [7:0] code
);

    logic [7:0] prev_keycode;

    // Remember last cycle's keycode so a held key is only reported once
    always_ff @(posedge Clk) begin
        if (Reset) begin
            prev_keycode <= 8'h00;
        end else begin
            prev_keycode <= keycode;
        end
    end

    assign press = (keycode != 8'h00) && (keycode != prev_keycode);
    assign code  = keycode;

endmodule

// File: rtl/battle_menu_ctrl.sv
// Turn-based battle menu controller.
//
// Starts a battle on an encounter pulse, lets side A and then side B pick a
// move with UP/DOWN/ENTER, holds an execute banner for EXEC_FRAMES video
// frames, resolves the round and repeats until one side is knocked out or a
// side picks RUN. ENTER on the result screen returns to the overworld.
//
// Ports:
//   Clk, Reset  - clock and synchronous active-high reset
//   keycode     - current HID keycode, 0 = no key
//   encounter   - one-cycle pulse starting a battle (honoured in IDLE only)
//   frame_tick  - one-cycle pulse per video frame
//   scene       - 01 overworld, 10 battle
//   sel_A/sel_B - highlighted move for each side
//   turn        - 1 while side B is selecting
//   execute_on  - execute banner visible
//   hp_A/hp_B   - hit points
//   winner      - 00 none, 01 A, 10 B
//   battle_done - high on the result screen
module battle_menu_ctrl
    import battle_menu_ctrl_pkg::*;
#(
    parameter int HP_INIT     = 8,
    parameter int DMG         = 3,
    parameter int EXEC_FRAMES = 60
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    input  logic       encounter,
    input  logic       frame_tick,
    output logic [1:0] scene,
    output logic [1:0] sel_A,
    output logic [1:0] sel_B,
    output logic       turn,
    output logic       execute_on,
    output logic [3:0] hp_A,
    output logic [3:0] hp_B,
    output logic [1:0] winner,
    output logic       battle_done
);

    localparam int         CNT_W   = (EXEC_FRAMES > 1) ? $clog2(EXEC_FRAMES) : 1;
    localparam logic [3:0] HP_LOAD = 4'(HP_INIT);
    localparam logic [3:0] DMG_4   = 4'(DMG);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] frame_cnt;
    logic             frame_last;
    logic             key_press;
    logic [7:0]       key_code;
    logic             up_evt;
    logic             down_evt;
    logic             enter_evt;
    logic [3:0]       hp_a_res;
    logic [3:0]       hp_b_res;

    key_edge_detect u_key_edge_detect (
        .Clk     (Clk),
        .Reset   (Reset),
        .keycode (keycode),
        .press   (key_press),
        .code    (key_code)
    );

    assign up_evt     = key_press && (key_code == KEY_UP);
    assign down_evt   = key_press && (key_code == KEY_DOWN);
    assign enter_evt  = key_press && (key_code == KEY_ENTER);
    assign frame_last = (frame_cnt == CNT_W'(EXEC_FRAMES - 1));

    // Hit points after this round; only the loser takes damage, a tie
    // leaves both untouched. Used by RESOLVE for both the hp update and
    // the knockout decision.
    always_comb begin
        hp_a_res = hp_A;
        hp_b_res = hp_B;
        if (beats(move_t'(sel_B), move_t'(sel_A))) begin
            hp_a_res = sat_sub(hp_A, DMG_4);
        end
        if (beats(move_t'(sel_A), move_t'(sel_B))) begin
            hp_b_res = sat_sub(hp_B, DMG_4);
        end
    end

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; locking RUN ends the battle without a round
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (encounter) begin
                    state_next = ST_SEL_A;
                end
            end
            ST_SEL_A: begin
                if (enter_evt) begin
                    state_next = (sel_A == MOVE_RUN) ? ST_DONE : ST_SEL_B;
                end
            end
            ST_SEL_B: begin
                if (enter_evt) begin
                    state_next = (sel_B == MOVE_RUN) ? ST_DONE : ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (frame_tick && frame_last) begin
                    state_next = ST_RESOLVE;
                end
            end
            ST_RESOLVE: begin
                state_next = (hp_a_res == 4'd0 || hp_b_res == 4'd0) ? ST_DONE : ST_SEL_A;
            end
            ST_DONE: begin
                if (enter_evt) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Output decode from the state register only
    always_comb begin
        scene       = SCENE_BATTLE;
        turn        = 1'b0;
        execute_on  = 1'b0;
        battle_done = 1'b0;
        case (state)
            ST_IDLE:  scene       = SCENE_OVERWORLD;
            ST_SEL_B: turn        = 1'b1;
            ST_EXEC:  execute_on  = 1'b1;
            ST_DONE:  battle_done = 1'b1;
            default: ;
        endcase
    end

    // Datapath: cursors, hit points, winner and the banner frame counter.
    // Winner and hp keep their values through DONE and IDLE until the next
    // encounter reloads them.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sel_A     <= 2'd0;
            sel_B     <= 2'd0;
            hp_A      <= HP_LOAD;
            hp_B      <= HP_LOAD;
            winner    <= WIN_NONE;
            frame_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (encounter) begin
                        sel_A  <= 2'd0;
                        sel_B  <= 2'd0;
                        hp_A   <= HP_LOAD;
                        hp_B   <= HP_LOAD;
                        winner <= WIN_NONE;
                    end
                end
                ST_SEL_A: begin
                    if (up_evt) begin
                        sel_A <= sel_A - 2'd1;
                    end else if (down_evt) begin
                        sel_A <= sel_A + 2'd1;
                    end else if (enter_evt && sel_A == MOVE_RUN) begin
                        winner <= WIN_NONE;
                    end
                end
                ST_SEL_B: begin
                    if (up_evt) begin
                        sel_B <= sel_B - 2'd1;
                    end else if (down_evt) begin
                        sel_B <= sel_B + 2'd1;
                    end else if (enter_evt) begin
                        frame_cnt <= '0;
                        if (sel_B == MOVE_RUN) begin
                            winner <= WIN_NONE;
                        end
                    end
                end
                ST_EXEC: begin
                    if (frame_tick && !frame_last) begin
                        frame_cnt <= frame_cnt + CNT_W'(1);
                    end
                end
                ST_RESOLVE: begin
                    hp_A <= hp_a_res;
                    hp_B <= hp_b_res;
                    if (hp_a_res == 4'd0) begin
                        winner <= WIN_B;
                    end else if (hp_b_res == 4'd0) begin
                        winner <= WIN_A;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
